uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart transmit path (wr_uart/w_data/tx_full) among NREQ byte-stream
//   requesters. Round-robin grant per frame: the grant is held until the requester
//   marks the last byte or MAX_BURST bytes have been sent.
//   Sits between client logic and the uart instance; drives its wr_uart and w_data.
// PARAMETERS
//   NREQ       4   number of requesters (2..16)
//   DBIT       8   data bits per byte; matches uart DBIT
//   MAX_BURST  16  max bytes per grant before forced rotation (1..255)
// PORTS
//   clk       in   1          system clock
//   reset     in   1          synchronous, active-high reset
//   req       in   NREQ       req[i]=1: requester i has a valid byte on its data slice
//   req_data  in   NREQ*DBIT  byte of requester i at [i*DBIT +: DBIT]
//   req_last  in   NREQ       byte presented by requester i is the last of its frame
//   req_ack   out  NREQ       one-hot; byte of requester i is accepted this cycle
//   gnt       out  NREQ       one-hot current grant; 0 when idle
//   busy      out  1          state != IDLE
//   tx_full   in   1          uart tx FIFO full
//   wr_uart   out  1          write strobe to uart
//   w_data    out  DBIT       byte to uart
// BEHAVIOUR
// - Reset (sync): state=IDLE, gnt=0, rr_ptr=0, burst_cnt=0.
//   Resulting outputs: wr_uart=0, req_ack=0, busy=0, w_data=0.
//   Mid-frame reset aborts the frame; the partial frame is not resumed.
// - States: IDLE, HDR (only with the macro below), XFER.
// - IDLE: if any req, pick the first set req[k], searching k = rr_ptr, rr_ptr+1, ...
//   modulo NREQ. Register gnt=onehot(k) and burst_cnt=0.
//   Next state is XFER (HDR with the macro). Arbitration costs 1 cycle; no write in IDLE.
// - XFER, combinational (Mealy):
//   wr_uart = req[g] & ~tx_full; req_ack[g] = wr_uart; w_data = req_data slice g.
//   w_data = 0 when not XFER/HDR.
// - Per accepted byte, burst_cnt is incremented.
//   If req_last[g] is set, or burst_cnt+1 == MAX_BURST, then:
//   state -> IDLE, gnt -> 0, rr_ptr -> (g+1) mod NREQ.
// - Granted requester drops req mid-frame: grant held, no write, no timeout.
// - tx_full=1: no write and no ack; state and burst_cnt hold. The requester keeps
//   req/data stable until acked.
// - Requests from non-granted requesters never get an ack; they wait for rotation.
// - Non-granted requesters may change req freely.
// - Back-to-back frames always pass through IDLE (one idle cycle between frames).
// - burst_cnt is 8 bits; it saturates only at the MAX_BURST compare, so it never wraps.
// CONFIGURATION
//   UART_ARB_ID_HDR_EN defined:
//     After IDLE, enter HDR and emit one header byte before the frame:
//     w_data = {4'hA, k[3:0]}, zero-padded/truncated to DBIT.
//     wr_uart = ~tx_full in HDR; req_ack = 0 in HDR.
//     When written -> XFER. The header is not counted in burst_cnt.
//     Forced rotation re-emits the header on the next grant.
//   UART_ARB_ID_HDR_EN undefined:
//     HDR state and logic absent; IDLE -> XFER directly.
// TESTING
// 1 req0 sends 0x11,0x22,0x33 (last on 0x33), tx_full=0
//   -> wr_uart on 3 consecutive cycles with w_data 11,22,33; req_ack=0001 each;
//      gnt 0001 then 0 next cycle.
// 2 After reset, req0 and req1 both send 1-byte frames
//   -> req0 served first, then req1. A repeat of both gives req0 again
//      (rr_ptr=2 wraps to 0).
// 3 req1 frame with tx_full=1 for 5 cycles after its first byte
//   -> no wr_uart/ack for 5 cycles; w_data holds byte 2; resumes when tx_full=0.
// 4 MAX_BURST=4: req2 streams 6 bytes without last while req3 waits
//   -> 4 bytes from req2, IDLE, then gnt=1000; req2 remaining bytes later.
// 5 reset asserted mid-frame on byte 2 of req0
//   -> next cycle wr_uart=0, gnt=0, busy=0; after release req1 alone is granted.
// 6 UART_ARB_ID_HDR_EN, req1 sends 0x5A last
//   -> wr_uart writes 0xA1 then 0x5A; req_ack only on the 0x5A cycle.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between NREQ byte-stream requesters, the arbiter and one uart
// transmit port.
//
// Handshake: req[i] is the valid for requester i's req_data slice and
// req_last bit. A byte transfers on a cycle where req_ack[i] is high.
// req_ack[i] is only high when req[i] is high. A requester keeps its
// data and last bit stable while req is high and no ack has arrived.
// Toward the uart, wr_uart is a single-cycle write strobe. It is only
// asserted while tx_full is low.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DBIT = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic                 tx_full;
    logic                 wr_uart;
    logic [DBIT-1:0]      w_data;
    logic [1:0]           state_dbg;

    // Arbiter side
    modport slave (
        input  req, req_data, req_last, tx_full,
        output req_ack, gnt, busy, wr_uart, w_data, state_dbg
    );

    // Requester / uart side
    modport master (
        output req, req_data, req_last, tx_full,
        input  req_ack, gnt, busy, wr_uart, w_data, state_dbg
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmit port among NREQ requesters.
// A grant lasts for one frame. The frame ends when the requester marks its
// last byte, or when MAX_BURST bytes have been sent, whichever comes first.
// Optional macro UART_ARB_ID_HDR_EN: each grant first emits a header byte
// {4'hA, requester index} before the frame's data bytes.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DBIT      = 8,
    parameter int MAX_BURST = 16
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int              PW     = $clog2(NREQ);
    localparam logic [PW:0]     NREQ_W = (PW+1)'(NREQ);
    localparam logic [7:0]      MAXB_W = 8'(MAX_BURST);
    localparam logic [NREQ-1:0] ONE    = NREQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;

    logic              sel_req;
    logic              sel_last;
    logic [DBIT-1:0]   sel_data;
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [PW:0]       cand;
    logic [PW:0]       rr_inc;
    logic [7:0]        burst_inc;
    logic              wr_c;
    logic [NREQ-1:0]   ack_c;
    logic [DBIT-1:0]   wdata_c;
`ifdef UART_ARB_ID_HDR_EN
    logic [7:0]        hdr8;
`endif

    // Route the granted requester's valid, last flag and data byte
    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx_q == PW'(i)) begin
                sel_req  = bus.req[i];
                sel_last = bus.req_last[i];
                sel_data = bus.req_data[i*DBIT +: DBIT];
            end
        end
    end

    // Find the first active request at or after rr_ptr. The scan runs from
    // the far end backward, so the candidate nearest rr_ptr is written last
    // and wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (bus.req[cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    // Mealy outputs toward the uart and the requesters
    always_comb begin
        wr_c    = 1'b0;
        ack_c   = '0;
        wdata_c = '0;
`ifdef UART_ARB_ID_HDR_EN
        hdr8    = {4'hA, 4'(gidx_q)};
`endif
        case (state_q)
            ST_XFER: begin
                wr_c    = sel_req & ~bus.tx_full;
                ack_c   = wr_c ? gnt_q : '0;
                wdata_c = sel_data;
            end
`ifdef UART_ARB_ID_HDR_EN
            ST_HDR: begin
                wr_c    = ~bus.tx_full;
                wdata_c = DBIT'(hdr8);
            end
`endif
            default: ;
        endcase
    end

    // Next-state logic: arbitration, optional header, frame and burst end
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        burst_inc   = burst_cnt_q + 8'd1;
        rr_inc      = {1'b0, gidx_q} + (PW+1)'(1);
        if (rr_inc == NREQ_W) begin
            rr_inc = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d       = ONE << pick_idx;
                    gidx_d      = pick_idx;
                    burst_cnt_d = '0;
`ifdef UART_ARB_ID_HDR_EN
                    state_d     = ST_HDR;
`else
                    state_d     = ST_XFER;
`endif
                end
            end
`ifdef UART_ARB_ID_HDR_EN
            ST_HDR: begin
                if (wr_c) begin
                    state_d = ST_XFER;
                end
            end
`endif
            ST_XFER: begin
                if (wr_c) begin
                    burst_cnt_d = burst_inc;
                    if (sel_last || (burst_inc == MAXB_W)) begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        rr_ptr_d = rr_inc[PW-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset; reset abandons any partial frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign bus.wr_uart   = wr_c;
    assign bus.req_ack   = ack_c;
    assign bus.w_data    = wdata_c;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.state_dbg = state_q;

endmodule
